// File: rtl/mem_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pkg
// Description : Shared definitions for the MEM/WB pipeline stage: occupancy
//               state encoding, control-bundle bit positions and the payload
//               width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_pkg;

    // State encoding doubles as the occupancy count (0, 1 or 2 entries).
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Position of the write-back enable inside the control bundle.
    localparam int CTRL_WB_BIT = 0;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } state_e;

    // Width of one packed {ctrl, data, dst} entry.
    function automatic int PAY_W(input int ctrl_w, input int data_w, input int addr_w);
        return ctrl_w + data_w + addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_payload_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_payload_reg
// Description : Falling-edge payload register with load enable and
//               asynchronous active-low clear.
// Ports       : clk    - stage clock (state changes on falling edge)
//               rst_n  - asynchronous active-low clear
//               ld_i   - load enable
//               d_i    - payload to capture
//               q_o    - held payload
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe
// Description : MEM/WB pipeline stage with valid/ready handshake, synchronous
//               flush and an optional one-entry skid buffer. Strict FIFO order;
//               control bits are forced to zero whenever no entry is valid.
// Ports       : clk, rst_n               - falling-edge clock, async low reset
//               in_valid/in_ready        - MEM-side handshake
//               in_ctrl/in_data/in_dst   - MEM-side payload
//               flush                    - squash all held entries
//               out_valid/out_ready      - WB-side handshake
//               out_ctrl/out_data/out_dst- WB-side payload
//               occupancy                - entries held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 1,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_dst,
    output logic [1:0]        occupancy
);

    localparam int PW = PAY_W(CTRL_W, DATA_W, ADDR_W);

    logic [PW-1:0] in_pay;
    logic [PW-1:0] main_q;
    logic [PW-1:0] main_d;
    logic [PW-1:0] skid_q;
    logic          main_ld;
    logic          skid_ld;

    state_e        state_q;
    state_e        state_d;
    logic          valid_q;
    logic          rdy_q;
    logic [1:0]    occ_q;

    logic          acc;
    logic          con;

    assign in_pay = {in_ctrl, in_data, in_dst};
    assign acc    = in_valid & in_ready;
    assign con    = valid_q & out_ready;

    // Next-state and load-enable decode. Flush wins over everything; the data
    // registers are left untouched so they simply hold stale contents.
    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = in_pay;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (acc) begin
                        state_d = S_ONE;
                        main_ld = 1'b1;
                    end
                end
                S_ONE: begin
                    // Without a skid register acc in ONE implies con, so the
                    // first branch is only reachable when SKID is enabled.
                    if (acc && !con && (SKID != 0)) begin
                        state_d = S_TWO;
                        skid_ld = 1'b1;
                    end else if (acc) begin
                        main_ld = 1'b1;
                    end else if (con) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // Skid entry moves up to the head; it is never overtaken.
                    if (con) begin
                        state_d = S_ONE;
                        main_ld = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
            occ_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != S_EMPTY);
            rdy_q   <= (state_d != S_TWO);
            // State encoding equals the number of entries held.
            occ_q   <= state_d;
        end
    end

    pipe_payload_reg #(.W(PW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_payload_reg #(.W(PW)) u_skid (
            .clk   (clk),
            .rst_n (rst_n),
            .ld_i  (skid_ld),
            .d_i   (in_pay),
            .q_o   (skid_q)
        );
        // Registered ready: no combinational path from out_ready.
        assign in_ready = rdy_q;
    end else begin : g_no_skid
        assign skid_q   = '0;
        // Single register: accept whenever the slot is free or being drained.
        assign in_ready = !valid_q | out_ready;
    end

    assign out_valid = valid_q;
    assign out_ctrl  = main_q[PW-1 -: CTRL_W] & {CTRL_W{valid_q}};
    assign out_data  = main_q[ADDR_W +: DATA_W];
    assign out_dst   = main_q[ADDR_W-1:0];
    assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_pipe
// Description : Self-checking bench for mem_wb_pipe. A queue-based model of the
//               two-entry FIFO stage is compared with the SKID=1 instance after
//               every falling edge; directed literal checks pin the model and
//               exercise the SKID=0 build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe;

    logic        clk;
    logic        rst_n;

    // SKID=1 instance
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [0:0]  in_ctrl, out_ctrl;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_dst, out_dst;
    logic [1:0]  occupancy;

    // SKID=0 instance
    logic        z_in_valid, z_in_ready, z_flush, z_out_valid, z_out_ready;
    logic [0:0]  z_in_ctrl, z_out_ctrl;
    logic [31:0] z_in_data, z_out_data;
    logic [4:0]  z_in_dst, z_out_dst;
    logic [1:0]  z_occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CTRL_W(1), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_data(in_data), .in_dst(in_dst), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_dst(out_dst), .occupancy(occupancy)
    );

    mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CTRL_W(1), .SKID(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl),
        .in_data(z_in_data), .in_dst(z_in_dst), .flush(z_flush),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl),
        .out_data(z_out_data), .out_dst(z_out_dst), .occupancy(z_occupancy)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: FIFO of up to two entries ----------------
    typedef struct packed {
        logic [0:0]  c;
        logic [31:0] d;
        logic [4:0]  a;
    } ent_t;

    ent_t mq[$];
    ent_t last_head;
    logic model_on = 1'b0;

    always @(negedge clk) begin
        bit m_acc;
        bit m_con;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            last_head = '0;
        end else begin
            m_acc = in_valid && (mq.size() < 2);
            m_con = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_con) void'(mq.pop_front());
                if (m_acc) begin
                    e.c = in_ctrl; e.d = in_data; e.a = in_dst;
                    mq.push_back(e);
                end
            end
            if (mq.size() > 0) last_head = mq[0];
        end
        #1;
        if (model_on) begin
            chk("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("m_out_ctrl",  32'(out_ctrl),  (mq.size() > 0) ? 32'(last_head.c) : 32'd0);
            chk("m_out_data",  out_data,       last_head.d);
            chk("m_out_dst",   32'(out_dst),   32'(last_head.a));
            chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
            chk("m_in_ready",  32'(in_ready),  32'(mq.size() < 2));
        end
    end

    // Drive one cycle's inputs right after a rising edge, return at the next.
    task automatic cyc(input logic v, input logic [31:0] d, input logic [4:0] a,
                       input logic c, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_dst    = a;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 0; in_data = 0; in_dst = 0; in_ctrl = 0; out_ready = 0; flush = 0;
        z_in_valid = 0; z_in_data = 0; z_in_dst = 0; z_in_ctrl = 0; z_out_ready = 0; z_flush = 0;

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        model_on = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ctrl",  32'(out_ctrl),  32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_dst",   32'(out_dst),   32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_z_in_ready", 32'(z_in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b1;

        // Single pass
        cyc(1, 32'hDEADBEEF, 5'd5, 1, 1, 0);
        chk("sp_out_valid", 32'(out_valid), 32'd1);
        chk("sp_out_data",  out_data,       32'hDEADBEEF);
        chk("sp_out_dst",   32'(out_dst),   32'd5);
        chk("sp_out_ctrl",  32'(out_ctrl),  32'd1);
        chk("sp_occupancy", 32'(occupancy), 32'd1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("drain_occ",   32'(occupancy), 32'd0);
        chk("drain_ctrl",  32'(out_ctrl),  32'd0);
        chk("drain_hold",  out_data,       32'hDEADBEEF);

        // Backpressure fill
        cyc(1, 32'h11, 5'd1, 1, 0, 0);
        cyc(1, 32'h22, 5'd2, 1, 0, 0);
        chk("bp_occ2",    32'(occupancy), 32'd2);
        chk("bp_ready0",  32'(in_ready),  32'd0);
        chk("bp_head",    out_data,       32'h11);
        cyc(1, 32'h33, 5'd3, 1, 0, 0);
        chk("bp_c_held_occ", 32'(occupancy), 32'd2);
        chk("bp_c_held_head", out_data, 32'h11);
        cyc(1, 32'h33, 5'd3, 1, 1, 0);
        chk("bp_second", out_data, 32'h22);
        cyc(1, 32'h33, 5'd3, 1, 1, 0);
        chk("bp_third", out_data, 32'h33);
        chk("bp_third_occ", 32'(occupancy), 32'd1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: one word per cycle, occupancy stays 1
        for (int i = 0; i < 100; i++) begin
            cyc(1, 32'hA000_0000 + 32'(i), 5'(i), i[0], 1, 0);
            chk("st_data", out_data, 32'hA000_0000 + 32'(i));
            chk("st_occ",  32'(occupancy), 32'd1);
        end
        cyc(0, 0, 0, 0, 1, 0);

        // Flush while full with a valid input pending
        cyc(1, 32'h55, 5'd5, 1, 0, 0);
        cyc(1, 32'h66, 5'd6, 1, 0, 0);
        cyc(1, 32'h77, 5'd7, 1, 0, 1);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ctrl",  32'(out_ctrl),  32'd0);
        chk("fl_occ",   32'(occupancy), 32'd0);
        chk("fl_ready", 32'(in_ready),  32'd1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("fl_never_valid", 32'(out_valid), 32'd0);
        chk("fl_stale_data",  out_data,       32'h55);

        // Reset while full
        cyc(1, 32'h88, 5'd8, 1, 0, 0);
        cyc(1, 32'h99, 5'd9, 1, 0, 0);
        chk("rm_occ2", 32'(occupancy), 32'd2);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rm_valid", 32'(out_valid), 32'd0);
        chk("rm_occ",   32'(occupancy), 32'd0);
        chk("rm_data",  out_data,       32'd0);
        @(posedge clk);
        rst_n = 1'b1;
        cyc(1, 32'h44, 5'd4, 1, 1, 0);
        chk("rm_first", out_data, 32'h44);
        chk("rm_first_valid", 32'(out_valid), 32'd1);
        cyc(0, 0, 0, 0, 1, 0);

        // SKID=0: combinational ready and replacing accept
        z_in_valid = 1; z_in_data = 32'hA1; z_in_dst = 5'd1; z_in_ctrl = 1; z_out_ready = 0;
        @(posedge clk);
        chk("z_first_valid", 32'(z_out_valid), 32'd1);
        chk("z_first_data",  z_out_data,       32'hA1);
        z_in_data = 32'hA2; z_in_dst = 5'd2;
        #1;
        chk("z_ready_low", 32'(z_in_ready), 32'd0);
        z_out_ready = 1;
        #1;
        chk("z_ready_comb", 32'(z_in_ready), 32'd1);
        @(posedge clk);
        chk("z_replace_data", z_out_data,       32'hA2);
        chk("z_replace_dst",  32'(z_out_dst),   32'd2);
        chk("z_replace_occ",  32'(z_occupancy), 32'd1);
        z_in_valid = 0;
        @(posedge clk);
        chk("z_empty_valid", 32'(z_out_valid), 32'd0);
        chk("z_empty_ctrl",  32'(z_out_ctrl),  32'd0);
        chk("z_empty_occ",   32'(z_occupancy), 32'd0);

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline stage with a valid/ready handshake, synchronous flush and an optional one-entry skid buffer.
- Carries the control bundle, the ALU/memory result and the destination register address from the MEM stage to the WB stage.
- Lets the WB stage stall without losing an in-flight instruction, and lets hazard logic squash the stage.
- Forces control bits to zero on bubbles so that a register write never fires on an invalid slot.

Parameters:
- DATA_W, 32, width of the result payload.
- ADDR_W, 5, width of the destination register address.
- CTRL_W, 1, width of the control bundle; bit 0 is the write-back enable.
- SKID, 1, 1 = two-entry (main + skid) buffering, 0 = single register with a combinational ready path.

Ports:
- clk  input  1  stage clock; all state updates on the falling edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  MEM stage presents a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- in_ctrl  input  CTRL_W  control bundle from MEM.
- in_data  input  DATA_W  result from MEM.
- in_dst  input  ADDR_W  destination register address from MEM.
- flush  input  1  squash all held entries.
- out_valid  output  1  WB-side entry is valid.
- out_ready  input  1  WB consumes this cycle.
- out_ctrl  output  CTRL_W  control bundle to WB; all zero when out_valid=0.
- out_data  output  DATA_W  result to WB.
- out_dst  output  ADDR_W  destination address to WB.
- occupancy  output  2  entries held (0..2).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=EMPTY; out_valid=0; out_ctrl=0, out_data=0, out_dst=0; occupancy=0; in_ready=1.
  - The skid register is cleared.
  - Reset mid-transfer discards all entries.
- Transfers:
  - acc = in_valid & in_ready; con = out_valid & out_ready; both evaluated at the falling edge.
  - Latency: an accepted entry appears on out_* after the same falling edge, so it is visible in the following cycle.
- States (SKID=1):
  - EMPTY: acc -> ONE, main<=in.
  - ONE: acc&con -> ONE, main<=in. acc&!con -> TWO, skid<=in. !acc&con -> EMPTY. Otherwise hold.
  - TWO: con -> ONE, main<=skid. Otherwise hold.
- in_ready (SKID=1):
  - in_ready = (state!=TWO), a registered decode with no combinational path from out_ready.
  - No accept is possible in TWO.
- SKID=0:
  - No TWO state.
  - in_ready = !out_valid | out_ready (combinational).
  - acc loads main, in both EMPTY and ONE.
- Ordering: strict FIFO; the skid entry is never overtaken.
- Flush:
  - Synchronous and highest priority.
  - Next state is EMPTY; any acc in the same cycle is dropped; con in the same cycle is still counted as consumed by WB.
  - Data registers may hold stale values.
  - out_ctrl reads as zero while out_valid=0.
- Bubble gating: out_ctrl = main_ctrl & {CTRL_W{out_valid}}. out_data and out_dst hold their last values.
- Hold: with no acc and no con, all outputs stay stable indefinitely.
- occupancy:
  - EMPTY=0, ONE=1, TWO=2.
  - Registered; updates on the same edge as the state.
- No wrap-around or overflow is possible: acc is blocked in TWO, and con requires out_valid.

Decomposition:
- Shared package mem_wb_pkg:
  - State encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - CTRL_WB_BIT=0.
  - Payload width function PAY_W = CTRL_W+DATA_W+ADDR_W.
- Sub-module pipe_payload_reg: PAY_W-wide falling-edge register with load enable and async active-low clear. Instantiate it as main and as skid; omit skid via generate when SKID=0.

Test Plan:
- Reset, then single pass:
  - rst_n low mid-cycle -> outputs 0 immediately, in_ready=1.
  - Release; drive in_valid=1, ctrl=1, data=0xDEADBEEF, dst=5, out_ready=1 for one edge -> next cycle out_valid=1, out_data=0xDEADBEEF, out_dst=5, out_ctrl=1, occupancy=1.
- Backpressure fill (SKID=1):
  - out_ready=0; push A=0x11 and B=0x22 on consecutive edges -> occupancy=2, in_ready=0, out_data=0x11.
  - A third push C=0x33 is held and not accepted.
  - Then out_ready=1 -> outputs 0x11, 0x22, 0x33 in order, with no loss or duplication.
- Simultaneous accept/consume in ONE: streaming 100 words with out_ready=1 -> occupancy stays 1, throughput is one word per cycle, and output order matches input.
- Flush:
  - In TWO with in_valid=1, assert flush for one edge -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
  - The flushed input never appears on out_*.
- Reset mid-operation: rst_n pulse while in TWO -> asynchronous clear; after release the first new push D=0x44 is the first output seen.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; toggling out_ready=1 -> in_ready=1 combinationally, and a replacing accept lands on the next edge.
